// File: rtl/bin_conv_sequencer.sv
// bin_conv_sequencer: sequential binary-to-BCD converter (shift-and-add-3).
// An accepted operand is converted over WIDTH SHIFT cycles; the packed BCD
// result, the captured operand (hex view) and its zero-extended copy (octal
// view) are then offered with a valid/ready handshake in DONE.
// Optional feature: define BIN_CONV_ABORT_EN to add an 'abort' input that
// drops an in-flight conversion back to IDLE without producing a result.
module bin_conv_sequencer #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      binary,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   dec,
  output logic [WIDTH-1:0]      hexa,
  output logic [WIDTH+1:0]      octal,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
`ifdef BIN_CONV_ABORT_EN
  ,
  input  logic                  abort
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      operand_q, operand_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]      hexa_q, hexa_d;
  logic [WIDTH+1:0]      octal_q, octal_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic [4*DIGITS-1:0]   adj_s;
  logic                  abort_s;

`ifdef BIN_CONV_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Add 3 to a BCD digit that is 5 or more so the next left shift carries correctly.
  function automatic logic [3:0] add3(input logic [3:0] digit);
    if (digit >= 4'd5) begin
      add3 = digit + 4'd3;
    end else begin
      add3 = digit;
    end
  endfunction

  // Pre-shift digit correction applied to every BCD digit in parallel.
  always_comb begin
    adj_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj_s[4*i +: 4] = add3(bcd_q[4*i +: 4]);
    end
  end

  // Next-state and datapath update; every register holds by default.
  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    hexa_d    = hexa_q;
    octal_d   = octal_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          operand_d = binary;
          bcd_d     = '0;
          cnt_d     = CW'(WIDTH);
          hexa_d    = binary;
          octal_d   = {2'b00, binary};
          state_d   = SHIFT;
        end else begin
          state_d   = IDLE;
        end
      end
      SHIFT: begin
        if (abort_s) begin
          state_d = IDLE;
        end else begin
          bcd_d     = {adj_s[4*DIGITS-2:0], operand_q[WIDTH-1]};
          operand_d = {operand_q[WIDTH-2:0], 1'b0};
          cnt_d     = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      DONE: begin
        if (abort_s || out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == SHIFT) || (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      operand_q   <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      hexa_q      <= '0;
      octal_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      operand_q   <= operand_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      hexa_q      <= hexa_d;
      octal_q     <= octal_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign dec       = bcd_q;
  assign hexa      = hexa_q;
  assign octal     = octal_q;

endmodule
